// File: rtl/ram_arbiter.sv
// Round-robin arbiter and pipeline sequencer sharing one single-port 256x16 synchronous RAM
// between the fetch port (0) and the data port (1); read data returns three cycles after grant.
module ram_arbiter #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_0,
    input  logic          we_0,
    input  logic [AW-1:0] addr_0,
    input  logic [DW-1:0] wdata_0,
    output logic          gnt_0,
    output logic          rvalid_0,
    output logic [DW-1:0] rdata_0,
    input  logic          req_1,
    input  logic          we_1,
    input  logic [AW-1:0] addr_1,
    input  logic [DW-1:0] wdata_1,
    output logic          gnt_1,
    output logic          rvalid_1,
    output logic [DW-1:0] rdata_1,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);

    logic          prio;
    logic          v1, port1, rd1;
    logic          v2, port2, rd2;
    logic          gnt_any, gnt_sel;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          capture;

    // Grants are held low during reset so nothing handshakes against a clearing pipeline.
    always_comb begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
        if (rst_n) begin
            if (req_0 && (!req_1 || !prio)) begin
                gnt_0 = 1'b1;
            end else if (req_1) begin
                gnt_1 = 1'b1;
            end
        end
    end

    assign gnt_any   = gnt_0 | gnt_1;
    assign gnt_sel   = gnt_1;
    assign sel_we    = gnt_sel ? we_1    : we_0;
    assign sel_addr  = gnt_sel ? addr_1  : addr_0;
    assign sel_wdata = gnt_sel ? wdata_1 : wdata_0;

    // Idle cycles keep address and data so the RAM just performs a harmless read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio     <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            v1       <= 1'b0;
            port1    <= 1'b0;
            rd1      <= 1'b0;
        end else if (gnt_any) begin
            prio     <= ~gnt_sel;
            ram_we   <= sel_we;
            ram_addr <= sel_addr;
            ram_din  <= sel_wdata;
            v1       <= 1'b1;
            port1    <= gnt_sel;
            rd1      <= ~sel_we;
        end else begin
            ram_we   <= 1'b0;
            v1       <= 1'b0;
        end
    end

    assign capture = v2 & rd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            port2    <= 1'b0;
            rd2      <= 1'b0;
            rvalid_0 <= 1'b0;
            rvalid_1 <= 1'b0;
            rdata_0  <= '0;
            rdata_1  <= '0;
        end else begin
            v2       <= v1;
            port2    <= port1;
            rd2      <= rd1;
            rvalid_0 <= capture & ~port2;
            rvalid_1 <= capture & port2;
            if (capture && !port2) begin
                rdata_0 <= ram_dout;
            end
            if (capture && port2) begin
                rdata_1 <= ram_dout;
            end
        end
    end

    assign busy = v1 | v2 | rvalid_0 | rvalid_1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, cycle-level reference model with a pending-read queue,
// grant vector table, directed corner sequences and randomized traffic.
module tb_ram_arbiter;
    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_0, we_0, req_1, we_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1;
    logic          gnt_0, gnt_1, rvalid_0, rvalid_1, ram_we, busy;
    logic [DW-1:0] rdata_0, rdata_1, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy)
    );

    logic [DW-1:0] ram_mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory updated in grant order, reads due three cycles after grant.
    typedef struct { int due; bit port; logic [DW-1:0] data; } rd_t;
    rd_t           pend[$];
    logic [DW-1:0] mem_m [256] = '{default: '0};
    logic [DW-1:0] m_rdata [2];
    bit            m_prio, hg1, hg2, hw1;
    logic [AW-1:0] ha1, m_addr;
    logic [DW-1:0] hd1, m_din;
    int            cyc = 0;

    always @(negedge clk) begin : monitor
        bit e_rv0, e_rv1, g_any, g;
        if (!rst_n) begin
            check("rst_gnt_0", gnt_0, 0);
            check("rst_gnt_1", gnt_1, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_ram_din", ram_din, 0);
            check("rst_rvalid", {rvalid_1, rvalid_0}, 0);
            check("rst_rdata_0", rdata_0, 0);
            check("rst_rdata_1", rdata_1, 0);
            check("rst_busy", busy, 0);
            pend.delete();
            m_rdata[0] = '0; m_rdata[1] = '0;
            m_prio = 0; hg1 = 0; hg2 = 0; hw1 = 0;
            ha1 = '0; hd1 = '0; m_addr = '0; m_din = '0;
        end else begin
            e_rv0 = 0; e_rv1 = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                if (pend[0].port) e_rv1 = 1; else e_rv0 = 1;
                m_rdata[pend[0].port] = pend[0].data;
                void'(pend.pop_front());
            end
            if (hg1) begin m_addr = ha1; m_din = hd1; end
            check("m_ram_we", ram_we, hg1 & hw1);
            check("m_ram_addr", ram_addr, m_addr);
            check("m_ram_din", ram_din, m_din);
            check("m_rvalid_0", rvalid_0, e_rv0);
            check("m_rvalid_1", rvalid_1, e_rv1);
            check("m_rdata_0", rdata_0, m_rdata[0]);
            check("m_rdata_1", rdata_1, m_rdata[1]);
            check("m_busy", busy, hg1 | hg2 | e_rv0 | e_rv1);
            g_any = req_0 | req_1;
            if (req_0 && req_1) g = m_prio;
            else g = req_1;
            check("m_gnt_0", gnt_0, g_any & !g);
            check("m_gnt_1", gnt_1, g_any & g);
            hg2 = hg1;
            hg1 = g_any;
            if (g_any) begin
                hw1 = g ? we_1 : we_0;
                ha1 = g ? addr_1 : addr_0;
                hd1 = g ? wdata_1 : wdata_0;
                m_prio = !g;
                if (hw1) mem_m[ha1] = hd1;
                else pend.push_back('{due: cyc + 3, port: g, data: mem_m[ha1]});
            end
        end
        cyc++;
    end

    typedef struct {
        bit req0, req1, we0, we1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        bit g0, g1;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_0 = 0; req_1 = 0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        idle(4);
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    function automatic logic [AW-1:0] raddr();
        if ($urandom_range(0, 9) == 0) return 8'hFF;
        return 8'($urandom_range(0, 7));
    endfunction

    task automatic rand_cycles(input int n);
        bit g0 = 0, g1 = 0;
        int r0 = 50, r1 = 50;
        for (int i = 0; i < n; i++) begin
            if (i % 200 == 0) begin
                r0 = $urandom_range(0, 100);
                r1 = $urandom_range(0, 100);
            end
            if (!req_0 || g0) begin
                req_0 = ($urandom_range(0, 99) < 32'(r0));
                we_0 = 1'($urandom_range(0, 1));
                addr_0 = raddr();
                wdata_0 = 16'($urandom);
            end
            if (!req_1 || g1) begin
                req_1 = ($urandom_range(0, 99) < 32'(r1));
                we_1 = 1'($urandom_range(0, 1));
                addr_1 = raddr();
                wdata_1 = 16'($urandom);
            end
            @(negedge clk);
            g0 = gnt_0; g1 = gnt_1;
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[$];
        rst_n = 1;
        req_0 = 0; we_0 = 0; addr_0 = '0; wdata_0 = '0;
        req_1 = 0; we_1 = 0; addr_1 = '0; wdata_1 = '0;
        #2 rst_n = 0;

        // reset with both requesting
        req_0 = 1; req_1 = 1;
        repeat (3) @(negedge clk);
        check("reset_gnt", {gnt_1, gnt_0}, 0);
        check("reset_rdata_0", rdata_0, 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        check("first_gnt_0", gnt_0, 1);
        check("first_gnt_1", gnt_1, 0);
        tick();
        idle(4);

        // write then read
        req_1 = 1; we_1 = 1; addr_1 = 8'h10; wdata_1 = 16'h00AB;
        @(negedge clk); check("wr_gnt_1", gnt_1, 1);
        tick();
        req_1 = 0; req_0 = 1; we_0 = 0; addr_0 = 8'h10;
        @(negedge clk);
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 8'h10);
        check("wr_ram_din", ram_din, 16'h00AB);
        check("rd_gnt_0", gnt_0, 1);
        tick();
        req_0 = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); check("wr_no_rvalid_1", rvalid_1, 0);
            tick();
        end
        @(negedge clk);
        check("rd_rvalid_0", rvalid_0, 1);
        check("rd_rdata_0", rdata_0, 16'h00AB);
        check("rd_rdata_1_hold", rdata_1, m_rdata[1]);
        tick();
        idle(3);

        // back-to-back single port
        for (int i = 0; i < 4; i++) begin
            req_1 = 1; we_1 = 1; addr_1 = 8'(i); wdata_1 = 16'h1000 + 16'(i);
            @(negedge clk); check("pre_gnt_1", gnt_1, 1);
            tick();
        end
        req_1 = 0;
        for (int i = 0; i < 8; i++) begin
            req_0 = (i < 4); we_0 = 0; addr_0 = 8'(i);
            @(negedge clk);
            if (i < 4) check("b2b_gnt_0", gnt_0, 1);
            if (i >= 3 && i <= 6) begin
                check("b2b_rvalid_0", rvalid_0, 1);
                check("b2b_rdata_0", rdata_0, 16'h1000 + 16'(i - 3));
            end
            if (i == 6) check("b2b_busy_last", busy, 1);
            if (i == 7) begin
                check("b2b_rvalid_end", rvalid_0, 0);
                check("b2b_busy_drop", busy, 0);
            end
            tick();
        end
        idle(2);

        // boundary address
        req_0 = 1; we_0 = 1; addr_0 = 8'hFF; wdata_0 = 16'hBEEF;
        @(negedge clk); check("bnd_wr_gnt", gnt_0, 1);
        tick();
        req_0 = 0; req_1 = 1; we_1 = 0; addr_1 = 8'hFF;
        @(negedge clk); check("bnd_rd_gnt", gnt_1, 1);
        tick();
        addr_1 = 8'h00;
        tick();
        req_1 = 0;
        tick();
        @(negedge clk);
        check("bnd_rvalid_1", rvalid_1, 1);
        check("bnd_rdata_ff", rdata_1, 16'hBEEF);
        tick();
        @(negedge clk);
        check("bnd_rdata_00", rdata_1, 16'h1000);
        tick();
        idle(2);

        // continuous contention from reset release
        do_reset();
        for (int i = 0; i < 16; i++) begin
            req_0 = 1; we_0 = 0; addr_0 = 8'h20;
            req_1 = 1; we_1 = 1; addr_1 = 8'h20;
            if (i % 2 == 0) wdata_1 = 16'h3000 + 16'(i);
            @(negedge clk);
            check("con_gnt_0", gnt_0, (i % 2 == 0));
            check("con_gnt_1", gnt_1, (i % 2 == 1));
            if (i >= 3) check("con_rvalid_0", rvalid_0, (i % 2 == 1));
            if (i >= 5 && i % 2 == 1) check("con_rdata_0", rdata_0, 16'h3000 + 16'(i - 5));
            tick();
        end

        // grant vector table
        vecs.push_back('{1, 1, 0, 0, 8'h05, 8'h06, 16'h0, 16'h0,    1, 0});
        vecs.push_back('{1, 1, 0, 0, 8'h07, 8'h06, 16'h0, 16'h0,    0, 1});
        vecs.push_back('{1, 1, 0, 1, 8'h07, 8'h07, 16'h0, 16'h7777, 1, 0});
        vecs.push_back('{0, 1, 0, 1, 8'h07, 8'h07, 16'h0, 16'h7777, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 8'h00, 8'h00, 16'h0, 16'h0,    0, 0});
        vecs.push_back('{0, 1, 0, 0, 8'h00, 8'h07, 16'h0, 16'h0,    0, 1});
        vecs.push_back('{1, 0, 1, 0, 8'h08, 8'h00, 16'h8888, 16'h0, 1, 0});
        vecs.push_back('{1, 1, 0, 0, 8'h08, 8'h07, 16'h0, 16'h0,    0, 1});
        vecs.push_back('{1, 0, 0, 0, 8'h08, 8'h07, 16'h0, 16'h0,    1, 0});
        vecs.push_back('{1, 1, 0, 0, 8'hFF, 8'h08, 16'h0, 16'h0,    0, 1});
        vecs.push_back('{1, 0, 0, 0, 8'hFF, 8'h08, 16'h0, 16'h0,    1, 0});
        vecs.push_back('{0, 0, 0, 0, 8'h00, 8'h00, 16'h0, 16'h0,    0, 0});
        do_reset();
        foreach (vecs[i]) begin
            req_0 = vecs[i].req0; we_0 = vecs[i].we0; addr_0 = vecs[i].a0; wdata_0 = vecs[i].d0;
            req_1 = vecs[i].req1; we_1 = vecs[i].we1; addr_1 = vecs[i].a1; wdata_1 = vecs[i].d1;
            @(negedge clk);
            check("tbl_gnt_0", gnt_0, vecs[i].g0);
            check("tbl_gnt_1", gnt_1, vecs[i].g1);
            tick();
        end
        idle(4);

        // reset in the middle of a read
        req_0 = 1; we_0 = 0; addr_0 = 8'h07;
        @(negedge clk); check("mid_gnt_0", gnt_0, 1);
        tick();
        req_0 = 0;
        tick();
        rst_n = 0;
        @(negedge clk); check("mid_rvalid_in_rst", rvalid_0, 0);
        tick();
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("mid_no_rvalid", rvalid_0, 0);
            check("mid_rdata_0", rdata_0, 0);
            tick();
        end
        req_0 = 1; req_1 = 1; we_0 = 0; we_1 = 0; addr_0 = 8'h01; addr_1 = 8'h02;
        @(negedge clk);
        check("mid_next_gnt_0", gnt_0, 1);
        check("mid_next_gnt_1", gnt_1, 0);
        tick();
        idle(4);

        rand_cycles(3000);
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer for the single-port 256 x 16 synchronous RAM. It shares the RAM between the instruction-fetch port (port 0) and the data load/store port (port 1). It issues at most one RAM access per cycle with round-robin fairness, tracks in-flight reads through the RAM's one-cycle read latency, and returns read data to the originating port with a valid pulse. It sits between the CPU control/datapath and the RAM instance.

## Interface
- DW, 16, data width (RAM word; 8-bit data is zero-extended by requesters)
- AW, 8, address width (256 words)

Ports (x = 0 fetch, x = 1 data):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_x  in  1  access request; held with stable cmd fields until granted
- we_x  in  1  1 = write, 0 = read
- addr_x  in  AW  word address
- wdata_x  in  DW  write data
- gnt_x  out  1  combinational grant; handshake completes on the edge where req_x & gnt_x
- rvalid_x  out  1  one-cycle pulse, read data for port x on rdata_x
- rdata_x  out  DW  registered read data; holds until the next read for port x completes
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  AW  RAM address (registered)
- ram_din  out  DW  RAM write data (registered)
- ram_dout  in  DW  RAM read data; valid the cycle after a read command is driven
- busy  out  1  any command or read in flight in the pipeline

## Operation
- Priority pointer `prio` is 1 bit and resets to 0.
- Grant logic, per cycle:
  - Only req_0 high: grant port 0.
  - Only req_1 high: grant port 1.
  - Both high: grant port `prio`.
  - Neither high: no grant.
- At most one gnt_x is high in any cycle.
- On any grant to port g, `prio` <= ~g on that edge. Under continuous contention, grants alternate.
- Command stage (S1): on a grant, register {ram_we, ram_addr, ram_din} <= {we_g, addr_g, wdata_g}, plus tag {v1=1, port1=g, rd1=~we_g}.
- On a cycle with no grant:
  - ram_we <= 0 and v1 <= 0.
  - ram_addr and ram_din hold their previous values. The RAM performs a harmless read.
- Capture stage (S2): {v2, port2, rd2} <= {v1, port1, rd1}. If v2 & rd2, rdata_{port2} <= ram_dout. The other port's rdata holds.
- Return stage: rvalid_x <= v2 & rd2 & (port2 == x). rvalid_x pulses for one cycle.
- Writes produce no rvalid.
- busy = v1 | v2 | rvalid_0 | rvalid_1.
- Requests to the same address are executed in grant order. A read granted any cycle after a write to the same address returns the new data.
- Address arithmetic: no wrap or offset logic; addr_x passes through unchanged. 0xFF is legal.

## Timing
- Grant in cycle t (combinational from req). The RAM command is driven during t+1. The RAM executes at the end of t+1. ram_dout is valid in t+2 and captured at the end of t+2.
- rvalid_x and the new rdata_x appear in t+3. Read latency is 3 cycles from grant.
- Throughput: 1 access per cycle total. A single requester holding req with new fields every cycle is granted every cycle.
- A requester must not change its cmd fields while req_x=1 & gnt_x=0.
- Reset (asynchronous, any cycle, including mid-operation):
  - ram_we, v1, v2, rd1, rd2, rvalid_x = 0.
  - ram_addr = 0, ram_din = 0, rdata_x = 0, prio = 0.
  - In-flight reads are discarded; no rvalid is produced for them after release.
- gnt_x is 0 while rst_n = 0.

## Test plan
- Reset: hold rst_n=0 with req_0=req_1=1 -> gnt_x=0, ram_we=0, ram_addr=0x00, rdata_x=0x0000, rvalid_x=0, busy=0; after release, first grant goes to port 0.
- Write then read: port 1 writes 0x00AB to 0x10 (granted cycle t) -> ram_we=1, ram_addr=0x10, ram_din=0x00AB in t+1, no rvalid_1; port 0 reads 0x10 granted t+1 -> rvalid_0 in t+4, rdata_0=0x00AB, rdata_1 unchanged.
- Contention: both ports request continuously from reset release -> grants 0,1,0,1,...; each port's rvalid arrives 3 cycles after each of its grants with the correct data.
- Back-to-back single port: after preloading 0x00..0x03 with 0x1000..0x1003, port 0 reads 0x00..0x03 on consecutive cycles -> gnt_0 every cycle, rvalid_0 for 4 consecutive cycles, rdata_0 = 0x1000, 0x1001, 0x1002, 0x1003 in order; busy drops 1 cycle after the last rvalid.
- Boundary address: write 0xBEEF to 0xFF, then read 0xFF -> rdata=0xBEEF; address 0x00 is unaffected.
- Reset mid-read: read granted in t, rst_n pulsed low in t+2 -> no rvalid after release, rdata_x=0x0000, next grant goes to port 0.
